// File: rtl/axis_packet_gate.sv
// Gates an AXI-Stream packet flow into the DMA: discards beats until started,
// aligns to a packet boundary, forwards n whole packets, then closes again.
module axis_packet_gate #(
   parameter int TDATA_WIDTH = 8,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   resetn,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                   s_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tlast,
   input  logic                   start,
   input  logic                   abort,
   input  logic [COUNT_WIDTH-1:0] n_packets,
   output logic                   busy,
   output logic                   done,
   output logic                   aborted,
   output logic [COUNT_WIDTH-1:0] pkt_count,
   output logic [COUNT_WIDTH-1:0] drop_count
);

   typedef enum logic [1:0] {IDLE, SYNC, PASS} state_t;

   state_t                 state;
   logic                   at_boundary;
   logic                   abort_pend;
   logic [COUNT_WIDTH-1:0] target;
   logic                   beat;
   logic                   tlast_beat;
   logic                   bnd_now;
   logic [COUNT_WIDTH-1:0] pkt_next;

   // Closed states sink everything so upstream never stalls.
   assign s_axis_tready = (state == PASS) ? m_axis_tready : 1'b1;
   assign m_axis_tvalid = (state == PASS) & s_axis_tvalid;
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tlast  = s_axis_tlast;

   assign beat       = s_axis_tvalid & s_axis_tready;
   assign tlast_beat = beat & s_axis_tlast;
   assign bnd_now    = beat ? s_axis_tlast : at_boundary;
   assign pkt_next   = pkt_count + 1'b1;

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         pkt_count   <= '0;
         drop_count  <= '0;
         at_boundary <= 1'b1;
         target      <= '0;
         abort_pend  <= 1'b0;
      end else begin
         if (beat)
            at_boundary <= s_axis_tlast;
         if (state != PASS && tlast_beat && drop_count != {COUNT_WIDTH{1'b1}})
            drop_count <= drop_count + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  done      <= 1'b0;
                  aborted   <= 1'b0;
                  pkt_count <= '0;
                  target    <= n_packets;
                  if (n_packets == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= bnd_now ? PASS : SYNC;
                  end
               end
            end
            SYNC: begin
               if (abort) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (tlast_beat) begin
                  state <= PASS;
               end
            end
            PASS: begin
               if (tlast_beat) begin
                  pkt_count <= pkt_next;
                  if (pkt_next == target) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     abort_pend <= 1'b0;
                  end else if (abort_pend || abort) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     aborted    <= 1'b1;
                     abort_pend <= 1'b0;
                  end
               end else if (abort) begin
                  // Between packets we can stop at once; mid-packet we must finish it.
                  if (at_boundary && !beat) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     aborted    <= 1'b1;
                     abort_pend <= 1'b0;
                  end else begin
                     abort_pend <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_packet_gate.sv
// Randomized bench for axis_packet_gate: packet-level reference model,
// per-cycle output comparison and a forwarded-beat scoreboard.
module tb_axis_packet_gate;

   logic        clk = 1'b0;
   logic        resetn;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tlast;
   logic        start;
   logic        abort;
   logic [31:0] n_packets;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [31:0] pkt_count;
   logic [31:0] drop_count;

   axis_packet_gate #(.TDATA_WIDTH(8), .COUNT_WIDTH(32)) dut (
      .aclk(clk), .resetn(resetn),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .start(start), .abort(abort), .n_packets(n_packets),
      .busy(busy), .done(done), .aborted(aborted),
      .pkt_count(pkt_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: gate open/aligning flags, packets still owed, stop request.
   bit          mo, ms, mprev, mstop, mdone, mab;
   int unsigned mleft, mfwd, mdrop;
   bit          lb_rdy, lb_bt, lb_tl;
   logic [8:0]  exp_q[$];
   logic [8:0]  dut_q[$];

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mo = 0; ms = 0; mprev = 1; mstop = 0; mdone = 0; mab = 0;
         mleft = 0; mfwd = 0; mdrop = 0;
         exp_q.delete();
      end else begin
         lb_rdy = mo ? m_axis_tready : 1'b1;
         lb_bt  = s_axis_tvalid && lb_rdy;
         lb_tl  = lb_bt && s_axis_tlast;
         if (mo && lb_bt) exp_q.push_back({s_axis_tlast, s_axis_tdata});
         if (!mo && lb_tl && mdrop != 32'hFFFF_FFFF) mdrop++;
         if (!mo && !ms) begin
            if (start) begin
               mdone = 0; mab = 0; mfwd = 0;
               if (n_packets == 0) mdone = 1;
               else begin
                  mleft = n_packets;
                  if (lb_bt ? s_axis_tlast : mprev) mo = 1; else ms = 1;
               end
            end
         end else if (ms) begin
            if (abort) begin ms = 0; mab = 1; end
            else if (lb_tl) begin ms = 0; mo = 1; end
         end else begin
            if (lb_tl) begin
               mfwd++; mleft--;
               if (mleft == 0) begin mo = 0; mstop = 0; mdone = 1; end
               else if (mstop || abort) begin mo = 0; mstop = 0; mab = 1; end
            end else if (abort) begin
               if (mprev && !lb_bt) begin mo = 0; mab = 1; end
               else mstop = 1;
            end
         end
         if (lb_bt) mprev = s_axis_tlast;
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (resetn) begin
         chk("m_tvalid", m_axis_tvalid, mo & s_axis_tvalid);
         chk("s_tready", s_axis_tready, mo ? m_axis_tready : 1'b1);
         if (m_axis_tvalid) begin
            chk("m_tdata", m_axis_tdata, s_axis_tdata);
            chk("m_tlast", m_axis_tlast, s_axis_tlast);
         end
         chk("busy", busy, mo | ms);
         chk("done", done, mdone);
         chk("aborted", aborted, mab);
         chk("pkt_count", pkt_count, mfwd);
         chk("drop_count", drop_count, mdrop);
         if (m_axis_tvalid && m_axis_tready) dut_q.push_back({m_axis_tlast, m_axis_tdata});
      end
   end

   int idx;
   bit rand_v;
   int rmode;
   int cyc;

   task automatic step();
      bit hs;
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      cyc++;
      start = 0; abort = 0;
      if (hs) begin idx = (idx + 1) % 4; s_axis_tdata = 8'($urandom); end
      if (hs || !s_axis_tvalid) s_axis_tvalid = rand_v ? ($urandom % 4 != 0) : 1'b1;
      s_axis_tlast = (idx == 3);
      case (rmode)
         1: m_axis_tready = ~m_axis_tready;
         2: m_axis_tready = ($urandom % 3 != 0);
         default: m_axis_tready = 1'b1;
      endcase
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (busy && k < bound) begin step(); k++; end
      chk("idle_within_bound", {31'd0, busy}, 32'd0);
   endtask

   task automatic sb_check(input string nm);
      chk({nm, "_len"}, dut_q.size(), exp_q.size());
      for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++)
         chk({nm, "_beat"}, {23'd0, dut_q[i]}, {23'd0, exp_q[i]});
      dut_q.delete(); exp_q.delete();
   endtask

   task automatic to_idx(input int t);
      int k = 0;
      while ((idx != t || !s_axis_tvalid) && k < 50) begin step(); k++; end
   endtask

   initial begin
      resetn = 0; start = 0; abort = 0; n_packets = 0;
      s_axis_tvalid = 1; s_axis_tdata = 8'h11; s_axis_tlast = 0;
      m_axis_tready = 1; idx = 0; rand_v = 0; rmode = 0; cyc = 0;
      #1;
      chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drop", drop_count, 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1;

      // Three packets with no start: all dropped.
      repeat (12) step();
      chk("drop_after_3pkts", drop_count, 32'd3);
      chk("no_fwd_idle", dut_q.size(), 32'd0);

      // Start on the 2nd beat of a packet.
      to_idx(1);
      n_packets = 2; start = 1;
      step();
      wait_idle(100);
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_pkt", pkt_count, 32'd2);
      chk("t2_nbeats", dut_q.size(), 32'd8);
      if (dut_q.size() == 8) begin
         chk("t2_tlast4", {31'd0, dut_q[3][8]}, 32'd1);
         chk("t2_tlast8", {31'd0, dut_q[7][8]}, 32'd1);
         chk("t2_notlast1", {31'd0, dut_q[0][8]}, 32'd0);
      end
      sb_check("t2");

      // Start coincident with a tlast beat.
      to_idx(3);
      n_packets = 1; start = 1;
      step();
      chk("t3_busy", {31'd0, busy}, 32'd1);
      wait_idle(100);
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_nbeats", dut_q.size(), 32'd4);
      sb_check("t3");

      // DMA ready toggling during PASS.
      to_idx(3);
      rmode = 1;
      n_packets = 2; start = 1;
      step();
      wait_idle(200);
      rmode = 0; m_axis_tready = 1;
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_pkt", pkt_count, 32'd2);
      chk("t4_nbeats", dut_q.size(), 32'd8);
      sb_check("t4");

      // Abort on the 2nd forwarded beat of the first packet.
      to_idx(3);
      n_packets = 5; start = 1;
      step();
      step();
      abort = 1;
      step();
      wait_idle(100);
      chk("t5_aborted", {31'd0, aborted}, 32'd1);
      chk("t5_done", {31'd0, done}, 32'd0);
      chk("t5_pkt", pkt_count, 32'd1);
      chk("t5_nbeats", dut_q.size(), 32'd4);
      sb_check("t5");

      // Zero-packet capture.
      n_packets = 0; start = 1;
      step();
      chk("t6_done", {31'd0, done}, 32'd1);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      repeat (3) step();

      // Reset pulse mid-PASS.
      to_idx(3);
      n_packets = 3; start = 1;
      step(); step(); step();
      #2 resetn = 0;
      #1;
      chk("t7_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("t7_s_tready", {31'd0, s_axis_tready}, 32'd1);
      chk("t7_busy", {31'd0, busy}, 32'd0);
      chk("t7_pkt", pkt_count, 32'd0);
      chk("t7_drop", drop_count, 32'd0);
      @(posedge clk); #1;
      idx = 0; s_axis_tlast = 0; s_axis_tvalid = 1;
      dut_q.delete();
      resetn = 1;
      n_packets = 1; start = 1;
      step();
      wait_idle(100);
      chk("t7_done", {31'd0, done}, 32'd1);
      chk("t7_pkt_after", pkt_count, 32'd1);
      sb_check("t7");

      // Randomized captures with random valid/ready, stray starts and aborts.
      rand_v = 1; rmode = 2;
      for (int it = 0; it < 25; it++) begin
         int gap;
         gap = $urandom_range(0, 6);
         repeat (gap) step();
         n_packets = $urandom_range(0, 3);
         start = 1;
         step();
         for (int k = 0; k < 400 && busy; k++) begin
            abort = ($urandom % 25 == 0);
            start = ($urandom % 30 == 0);
            n_packets = $urandom_range(0, 3);
            step();
         end
         chk("rand_idle", {31'd0, busy}, 32'd0);
         sb_check("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_packet_gate.md
Name: axis_packet_gate

Overview:
- Sits directly downstream of the packet tlast generator and upstream of the DMA S2MM stream port.
- Upstream runs continuously; this block discards beats until software issues a start.
- After start it aligns to the next packet boundary, forwards exactly n_packets whole packets, then returns to discarding.
- Upstream never stalls while the gate is closed, and the DMA only ever sees complete, tlast-terminated packets.

Parameters:
- TDATA_WIDTH, 8, stream data width in bits.
- COUNT_WIDTH, 32, width of the packet-target, packet-count and drop-count fields.

Ports:
- aclk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- s_axis_tdata  in  TDATA_WIDTH  upstream data
- s_axis_tlast  in  1  upstream end of packet
- m_axis_tvalid  out  1  DMA-side valid
- m_axis_tready  in  1  DMA-side ready
- m_axis_tdata  out  TDATA_WIDTH  DMA-side data
- m_axis_tlast  out  1  DMA-side end of packet
- start  in  1  single-cycle capture request
- abort  in  1  single-cycle cancel request
- n_packets  in  COUNT_WIDTH  packets to forward; sampled on an accepted start
- busy  out  1  high in SYNC or PASS
- done  out  1  sticky; set on normal completion, cleared by the next accepted start
- aborted  out  1  sticky; set on abort completion, cleared by the next accepted start
- pkt_count  out  COUNT_WIDTH  packets forwarded in the current or last capture
- drop_count  out  COUNT_WIDTH  tlast beats discarded while closed; saturating

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; m_axis_tvalid=0; busy=0; done=0; aborted=0; pkt_count=0; drop_count=0; at_boundary=1; target=0; abort_pend=0.
- Definition: beat = s_axis_tvalid & s_axis_tready.
- at_boundary: on every beat, in every state, it takes the value of s_axis_tlast.
- Closed states (IDLE, SYNC):
  - s_axis_tready=1 and m_axis_tvalid=0.
  - Every tlast beat increments drop_count, saturating at all-ones.
- PASS:
  - Pure combinational pass-through, zero latency: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, tdata and tlast copied.
  - m_axis_tdata and m_axis_tlast are don't-care when m_axis_tvalid=0.
- IDLE transitions:
  - start is accepted only in IDLE; start in any other state is ignored.
  - On accepted start: clear done, aborted and pkt_count; latch target=n_packets.
  - If n_packets==0: set done next cycle and stay in IDLE.
  - Otherwise, if the boundary is known this cycle, go to PASS; else go to SYNC.
  - Boundary known this cycle = (beat ? s_axis_tlast : at_boundary). This resolves a start coincident with a beat.
  - start and abort in the same IDLE cycle: start wins; abort is ignored.
- SYNC transitions:
  - A tlast beat moves to PASS next cycle; that beat is discarded and counted as dropped.
  - abort returns to IDLE next cycle and sets aborted.
- PASS transitions:
  - On each tlast beat, pkt_count increments.
  - If the new pkt_count equals target, go to IDLE and set done.
  - Else, if abort_pend is set or abort is high this cycle, go to IDLE and set aborted.
  - abort with at_boundary=1 and no beat this cycle: go to IDLE immediately and set aborted.
  - abort otherwise: set abort_pend; the current packet finishes and the block leaves PASS after its tlast beat.
  - done takes priority over aborted when both apply on the same beat.
  - abort_pend is cleared on leaving PASS.
- Width: pkt_count wraps modulo 2^COUNT_WIDTH; target compare is an exact equality.
- Reset asserted mid-packet returns everything to reset values asynchronously. Any partial packet already given to the DMA is the DMA's problem; it is not repaired.
- busy = (state != IDLE), registered.

Test Plan:
- Reset, upstream packets of 4 beats, no start → m_axis_tvalid stays 0, s_axis_tready stays 1; after 3 packets drop_count=3.
- start with n_packets=2 on the 2nd beat of a packet → remaining 2 beats dropped; next 8 beats forwarded with tlast on beats 4 and 8; then done=1, busy=0, pkt_count=2.
- start in the same cycle as a tlast beat, n_packets=1 → the very next beat is forwarded, no extra drop; done after 4 forwarded beats.
- m_axis_tready toggling 1010… during PASS → s_axis_tready mirrors it and no beat is lost or duplicated (compare against a scoreboard); done after 2 packets.
- abort on the 2nd forwarded beat of packet 1 with n_packets=5 → remaining beats of packet 1 forwarded through tlast; then aborted=1, done=0, pkt_count=1.
- start with n_packets=0 → done=1 next cycle, busy never rises.
- Reset pulse mid-PASS → all outputs return to reset values immediately; a later start behaves as the first one.
